// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared types and constants for the common-data-bus transmitter.
//   cdb_t          : broadcast record {br_en, br_target, value, tag, valid}
//   CDB_W          : width of cdb_t (70)
//   CDB_SRC_*      : source index assignment (ALU, MUL, CMP, LOAD)
//   CDB_VALID_BIT  : bit position of cdb_t.valid inside the packed vector
//   cdb_pack()     : builds a cdb_t from its fields
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

    typedef struct packed {
        logic        br_en;
        logic [31:0] br_target;
        logic [31:0] value;
        logic [3:0]  tag;
        logic        valid;
    } cdb_t;

    localparam int CDB_W         = $bits(cdb_t);
    localparam int CDB_SRC_ALU   = 0;
    localparam int CDB_SRC_MUL   = 1;
    localparam int CDB_SRC_CMP   = 2;
    localparam int CDB_SRC_LD    = 3;
    localparam int CDB_VALID_BIT = 0;

    function automatic cdb_t cdb_pack(input logic        br_en,
                                      input logic [31:0] br_target,
                                      input logic [31:0] value,
                                      input logic [3:0]  tag,
                                      input logic        valid);
        cdb_t c;
        c.br_en     = br_en;
        c.br_target = br_target;
        c.value     = value;
        c.tag       = tag;
        c.valid     = valid;
        return c;
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// -----------------------------------------------------------------------------
// cdb_src_fifo
// Per-source holding FIFO in front of the CDB arbiter.
// Parameters: BUF_DEPTH (power of 2, >= 2), DATA_W (payload width).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : discards every buffered entry at the edge
//   enq/enq_data: push request and payload (ignored when full or flushing)
//   deq         : pop request (ignored when empty or flushing)
//   head_data   : oldest entry
//   empty, count: occupancy, both straight from registered state
// -----------------------------------------------------------------------------
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    parameter int DATA_W    = CDB_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       enq,
    input  logic [DATA_W-1:0]          enq_data,
    input  logic                       deq,
    output logic [DATA_W-1:0]          head_data,
    output logic                       empty,
    output logic [$clog2(BUF_DEPTH):0] count
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_r [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              enq_ok_s;
    logic              deq_ok_s;

    assign enq_ok_s  = enq && (count_r < CNT_W'(BUF_DEPTH));
    assign deq_ok_s  = deq && (count_r != {CNT_W{1'b0}});
    assign head_data = mem_r[rd_ptr_r];
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;

    // Next occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        if (enq_ok_s && !deq_ok_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (!enq_ok_s && deq_ok_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Storage, pointers and count; pointers wrap naturally since depth is 2^n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (enq_ok_s) begin
                mem_r[wr_ptr_r] <= enq_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (deq_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Transmitter side of the common data bus: buffers functional-unit results
// in per-source FIFOs and broadcasts one per cycle, round-robin, on cdb_o.
// Parameters: NUM_SRC (0=ALU,1=MUL,2=CMP,3=LOAD), BUF_DEPTH, CDB_W.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : mispredict flush, drops everything buffered and incoming
//   src_valid  : per-source result valid
//   src_data   : per-source cdb_t payload, source i at [i*CDB_W +: CDB_W]
//   src_ready  : per-source FIFO has room (registered count only, 0 in reset)
//   cdb_o      : registered cdb_t broadcast
// Optional (macro CDB_ARB_PERF_EN):
//   perf_bcast_cnt : saturating count of broadcasts
//   perf_stall_cnt : saturating count of cycles with a refused src_valid
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int BUF_DEPTH = 2,
    parameter int CDB_W     = cdb_arbiter_pkg::CDB_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [NUM_SRC*CDB_W-1:0] src_data,
    output logic [NUM_SRC-1:0]       src_ready,
    output logic [CDB_W-1:0]         cdb_o
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [31:0]              perf_bcast_cnt,
    output logic [31:0]              perf_stall_cnt
`endif
);

    import cdb_arbiter_pkg::*;

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [NUM_SRC-1:0] enq_s;
    logic [NUM_SRC-1:0] deq_s;
    logic [NUM_SRC-1:0] empty_s;
    logic [CDB_W-1:0]   head_s  [NUM_SRC];
    logic [CNT_W-1:0]   count_s [NUM_SRC];

    logic [PTR_W-1:0]   rr_ptr_r;
    logic [PTR_W-1:0]   rr_ptr_nxt_s;
    logic [PTR_W-1:0]   grant_idx_s;
    logic [PTR_W-1:0]   cand_s;
    logic               grant_vld_s;
    logic [CDB_W-1:0]   cdb_r;
    logic [CDB_W-1:0]   cdb_nxt_s;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        cdb_src_fifo #(
            .BUF_DEPTH (BUF_DEPTH),
            .DATA_W    (CDB_W)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .enq       (enq_s[i]),
            .enq_data  (src_data[i*CDB_W +: CDB_W]),
            .deq       (deq_s[i]),
            .head_data (head_s[i]),
            .empty     (empty_s[i]),
            .count     (count_s[i])
        );
    end

    // Ready depends on the registered count only, so a full FIFO cannot
    // accept in the same cycle it is being drained.
    always_comb begin
        src_ready = {NUM_SRC{1'b0}};
        enq_s     = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rst_n && (count_s[i] < CNT_W'(BUF_DEPTH))) begin
                src_ready[i] = 1'b1;
            end else begin
                src_ready[i] = 1'b0;
            end
            enq_s[i] = src_valid[i] & src_ready[i] & ~flush;
        end
    end

    // Round-robin scan: first non-empty FIFO at or after rr_ptr, with wrap.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = {PTR_W{1'b0}};
        cand_s      = {PTR_W{1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            cand_s = PTR_W'((int'(rr_ptr_r) + k) % NUM_SRC);
            if (!grant_vld_s && !empty_s[cand_s]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Dequeue the granted head; a flush suppresses the grant entirely.
    always_comb begin
        deq_s = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_vld_s && !flush && (grant_idx_s == PTR_W'(i))) begin
                deq_s[i] = 1'b1;
            end else begin
                deq_s[i] = 1'b0;
            end
        end
    end

    // Next broadcast and pointer: idle cycles only drop valid, fields hold.
    always_comb begin
        cdb_nxt_s    = cdb_r;
        rr_ptr_nxt_s = rr_ptr_r;
        if (flush) begin
            cdb_nxt_s[CDB_VALID_BIT] = 1'b0;
        end else if (grant_vld_s) begin
            cdb_nxt_s                = head_s[grant_idx_s];
            cdb_nxt_s[CDB_VALID_BIT] = 1'b1;
            if (grant_idx_s == PTR_W'(NUM_SRC - 1)) begin
                rr_ptr_nxt_s = {PTR_W{1'b0}};
            end else begin
                rr_ptr_nxt_s = grant_idx_s + PTR_W'(1);
            end
        end else begin
            cdb_nxt_s[CDB_VALID_BIT] = 1'b0;
        end
    end

    // Broadcast register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_r    <= {CDB_W{1'b0}};
            rr_ptr_r <= {PTR_W{1'b0}};
        end else begin
            cdb_r    <= cdb_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

    assign cdb_o = cdb_r;

`ifdef CDB_ARB_PERF_EN
    logic [31:0] perf_bcast_r;
    logic [31:0] perf_stall_r;
    logic        stall_s;

    assign stall_s = |(src_valid & ~src_ready);

    // Saturating event counters; flush deliberately leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bcast_r <= 32'd0;
            perf_stall_r <= 32'd0;
        end else begin
            if (grant_vld_s && !flush && (perf_bcast_r != 32'hFFFF_FFFF)) begin
                perf_bcast_r <= perf_bcast_r + 32'd1;
            end
            if (stall_s && (perf_stall_r != 32'hFFFF_FFFF)) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
        end
    end

    assign perf_bcast_cnt = perf_bcast_r;
    assign perf_stall_cnt = perf_stall_r;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed and random stimulus for cdb_arbiter, checked every cycle against a
// queue-based reference model of the broadcast rules.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int D  = 2;
    localparam int W  = 70;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic [N-1:0]     src_valid;
    logic [N*W-1:0]   src_data;
    logic [N-1:0]     src_ready;
    logic [W-1:0]     cdb_o;
`ifdef CDB_ARB_PERF_EN
    logic [31:0]      perf_bcast_cnt;
    logic [31:0]      perf_stall_cnt;
`endif

    cdb_arbiter #(.NUM_SRC(N), .BUF_DEPTH(D), .CDB_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .cdb_o     (cdb_o)
`ifdef CDB_ARB_PERF_EN
        ,
        .perf_bcast_cnt (perf_bcast_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [W-1:0] mq [N][$];
    logic [W-1:0] exp_cdb;
    int           m_rr;
    int           m_bcast;
    int           m_stall;

    int vectors;
    int miscompares;

    logic [W-1:0] mul_pend [$];
    logic         mul_pre_rdy;
    logic         saw_mul_stall;
    logic [N-1:0] rv;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] rnd_cdb(input logic [3:0] tag);
        return cdb_pack(1'($urandom % 2), $urandom, $urandom, tag, 1'($urandom % 2));
    endfunction

    task automatic set_src(input int i, input logic [W-1:0] d);
        src_data[i*W +: W] = d;
    endtask

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (mq[i].size() < D);
        return r;
    endfunction

    // One clock edge of the reference behaviour.
    task automatic model_edge();
        logic [N-1:0] rdy;
        int g;
        int idx;
        rdy = model_ready();
        if (|(src_valid & ~rdy)) m_stall++;
        if (flush) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            exp_cdb[0] = 1'b0;
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (g < 0 && mq[idx].size() > 0) g = idx;
            end
            if (g >= 0) begin
                exp_cdb    = mq[g].pop_front();
                exp_cdb[0] = 1'b1;
                m_rr       = (g + 1) % N;
                m_bcast++;
            end else begin
                exp_cdb[0] = 1'b0;
            end
            for (int i = 0; i < N; i++)
                if (src_valid[i] && rdy[i]) mq[i].push_back(src_data[i*W +: W]);
        end
    endtask

    task automatic check_outputs();
        chk("cdb_o", cdb_o, exp_cdb);
        chk("src_ready", W'(src_ready), W'(model_ready()));
`ifdef CDB_ARB_PERF_EN
        chk("perf_bcast", W'(perf_bcast_cnt), W'(m_bcast));
        chk("perf_stall", W'(perf_stall_cnt), W'(m_stall));
`endif
    endtask

    task automatic cycle(input logic [N-1:0] v, input logic fl);
        src_valid = v;
        flush     = fl;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        src_valid = '0;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        src_valid = '0;
        flush     = 1'b0;
        #1;
        chk("reset_cdb", cdb_o, {W{1'b0}});
        chk("reset_ready", W'(src_ready), W'(4'h0));
        for (int i = 0; i < N; i++) mq[i].delete();
        exp_cdb = '0;
        m_rr    = 0;
        m_bcast = 0;
        m_stall = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_reset_ready", W'(src_ready), W'(4'hF));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        src_valid   = '0;
        src_data    = '0;

        // reset state
        do_reset();

        // 1. single ALU result, value 5, tag 3
        set_src(CDB_SRC_ALU, cdb_pack(1'b0, 32'h0, 32'h0000_0005, 4'd3, 1'b0));
        cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);
        chk("t1_value", W'(cdb_o[36:5]), W'(32'h5));
        chk("t1_tag", W'(cdb_o[4:1]), W'(4'd3));
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);

        // 2. all four sources in one cycle, tags 1..4, from a fresh pointer
        do_reset();
        for (int i = 0; i < N; i++) set_src(i, rnd_cdb(4'(i + 1)));
        cycle(4'b1111, 1'b0);
        for (int i = 0; i < 6; i++) cycle(4'b0000, 1'b0);

        // 3. MUL bursts three results while ALU and CMP stay busy
        do_reset();
        for (int i = 0; i < 3; i++) mul_pend.push_back(rnd_cdb(4'(8 + i)));
        saw_mul_stall = 1'b0;
        for (int c = 0; c < 12; c++) begin
            set_src(CDB_SRC_ALU, rnd_cdb(4'd1));
            set_src(CDB_SRC_CMP, rnd_cdb(4'd2));
            mul_pre_rdy = (mq[CDB_SRC_MUL].size() < D);
            if (mul_pend.size() > 0) begin
                set_src(CDB_SRC_MUL, mul_pend[0]);
                if (!mul_pre_rdy) saw_mul_stall = 1'b1;
                cycle(4'b0111, 1'b0);
                if (mul_pre_rdy) void'(mul_pend.pop_front());
            end else begin
                cycle(4'b0101, 1'b0);
            end
        end
        for (int i = 0; i < 8; i++) cycle(4'b0000, 1'b0);
        chk("t3_mul_all_sent", W'(mul_pend.size()), W'(0));
        chk("t3_mul_stalled", W'(saw_mul_stall), W'(1'b1));
`ifdef CDB_ARB_PERF_EN
        chk("t3_perf_stall_nonzero", W'(perf_stall_cnt != 32'd0), W'(1'b1));
`endif

        // 4. flush with LOAD entries buffered and a new valid in the flush cycle
        set_src(CDB_SRC_ALU, rnd_cdb(4'd5));
        set_src(CDB_SRC_LD, rnd_cdb(4'd6));
        cycle(4'b1001, 1'b0);
        set_src(CDB_SRC_LD, rnd_cdb(4'd7));
        cycle(4'b1000, 1'b0);
        set_src(CDB_SRC_LD, rnd_cdb(4'd8));
        cycle(4'b1000, 1'b1);
        chk("t4_flush_valid", W'(cdb_o[0]), W'(1'b0));
        cycle(4'b0000, 1'b0);
        chk("t4_after_flush1", W'(cdb_o[0]), W'(1'b0));
        cycle(4'b0000, 1'b0);
        chk("t4_after_flush2", W'(cdb_o[0]), W'(1'b0));
        chk("t4_ready_all", W'(src_ready), W'(4'hF));

        // 5. branch result pass-through from CMP
        set_src(CDB_SRC_CMP, cdb_pack(1'b1, 32'h6000_0040, 32'hDEAD_BEEF, 4'd7, 1'b0));
        cycle(4'b0100, 1'b0);
        cycle(4'b0000, 1'b0);
        chk("t5_br_en", W'(cdb_o[69]), W'(1'b1));
        chk("t5_br_target", W'(cdb_o[68:37]), W'(32'h6000_0040));
        chk("t5_tag", W'(cdb_o[4:1]), W'(4'd7));
        cycle(4'b0000, 1'b0);

        // 6. asynchronous reset in the middle of a burst
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) set_src(i, rnd_cdb(4'(c * 4 + i)));
            cycle(4'b1111, 1'b0);
        end
        #2;
        do_reset();
        set_src(CDB_SRC_ALU, rnd_cdb(4'd12));
        set_src(CDB_SRC_LD, rnd_cdb(4'd13));
        cycle(4'b1001, 1'b0);
        cycle(4'b0000, 1'b0);
        chk("t6_first_is_alu", W'(cdb_o[4:1]), W'(4'd12));
        cycle(4'b0000, 1'b0);
        chk("t6_second_is_ld", W'(cdb_o[4:1]), W'(4'd13));
        cycle(4'b0000, 1'b0);

        // random traffic with occasional flushes
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) set_src(i, rnd_cdb(4'($urandom)));
            rv = 4'($urandom);
            cycle(rv, ($urandom % 32) == 0);
        end
        for (int i = 0; i < 10; i++) cycle(4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Transmitter side of the common data bus. Collects completed results from the functional units and drives the single cdb_t broadcast consumed by the reservation stations, the ROB and fetch.
- Sources, by default: ALU, MUL, CMP/branch, load.
- Each source has a small per-source holding FIFO.
- Grants are round-robin, one broadcast per cycle.
- Sits between the functional-unit outputs and every CDB listener.

Parameters:
- NUM_SRC, 4, number of functional-unit sources (index 0=ALU, 1=MUL, 2=CMP, 3=LOAD).
- BUF_DEPTH, 2, entries per source holding FIFO (power of 2, ≥2).
- CDB_W, 70, width of cdb_t (br_en 1 + br_target 32 + value 32 + tag 4 + valid 1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  mispredict flush; discards all buffered results.
- src_valid  in  NUM_SRC  per-source result valid.
- src_data  in  NUM_SRC*CDB_W  per-source cdb_t payload; source i occupies bits [i*CDB_W +: CDB_W].
- src_ready  out  NUM_SRC  per-source FIFO can accept.
- cdb_o  out  CDB_W  registered cdb_t broadcast.

Behaviour:
- Reset (asynchronous, rst_n low):
  - cdb_o is all zeros, all FIFO counts are 0, rr_ptr=0.
  - src_ready is forced to 0 while rst_n is low.
  - Reset mid-operation loses all buffered results.
- Accept:
  - Source i enqueues on an edge where src_valid[i] && src_ready[i].
  - src_ready[i] = (count_i < BUF_DEPTH), from registered count only; there is no combinational path from the grant.
  - A full FIFO therefore does not accept in the cycle it is dequeued.
  - src_data[i].valid is ignored; the arbiter generates the output valid itself.
- Arbitration (combinational on FIFO heads, each cycle):
  - Starting at rr_ptr, scan upward (with wrap) for the first non-empty FIFO. That source is granted, its head is dequeued, and the head is loaded into cdb_o with cdb_o.valid=1.
  - After a grant to source g, rr_ptr <= (g+1) mod NUM_SRC.
  - With no non-empty FIFO: cdb_o.valid <= 0, the other cdb_o fields hold their previous values, and rr_ptr holds.
- Latency: result accepted at edge E is visible on cdb_o after edge E+1 at the earliest (2 cycles from src_valid assertion). Each cdb_o.valid pulse lasts exactly one cycle per result.
- Simultaneous enqueue and dequeue on the same non-full FIFO: count is unchanged and ordering is preserved.
- Per-source order is FIFO; cross-source order is round-robin.
- Wrap: FIFO read/write pointers wrap modulo BUF_DEPTH. rr_ptr wraps from NUM_SRC-1 to 0.
- Flush:
  - At the flush edge all counts go to 0, cdb_o.valid <= 0 and rr_ptr holds.
  - src_valid in the flush cycle is dropped.
  - No broadcast occurs in the cycle after a flush.
- br_en, br_target, value and tag pass through unmodified.

Optional Feature:
Macro CDB_ARB_PERF_EN.
- Defined: adds two 32-bit outputs, both reset to 0 and cleared by rst_n only (not by flush):
  - perf_bcast_cnt: increments on each cdb_o.valid.
  - perf_stall_cnt: increments on each cycle where any src_valid[i] && !src_ready[i].
  - Both counters saturate at 0xFFFFFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- rv32i_types gains cdb_t (already present) plus new constants: CDB_SRC_ALU=0, CDB_SRC_MUL=1, CDB_SRC_CMP=2, CDB_SRC_LD=3, and CDB_W.
- Sub-module cdb_src_fifo: one instance per source.
  - Parameter BUF_DEPTH.
  - Ports: clk, rst_n, flush, enq, enq_data, deq, head_data, empty, count.
- The arbiter instantiates NUM_SRC copies and contains the round-robin logic and the cdb_o register.

Test Plan:
1. Single source: ALU src_valid for one cycle with value=0x0000_0005, tag=3 → two cycles later cdb_o.valid=1, value=5, tag=3 for exactly one cycle; rr_ptr=1.
2. All four sources valid in the same cycle, tags 1,2,3,4 → broadcasts on four consecutive cycles in order ALU, MUL, CMP, LOAD; then valid=0.
3. Backpressure: MUL sends 3 results on back-to-back cycles while ALU and CMP are continuously valid → src_ready[1]=0 on the third cycle; no MUL result is lost or reordered once that source retries; perf_stall_cnt ≥1 when CDB_ARB_PERF_EN is defined.
4. Flush: two entries buffered in LOAD plus a new src_valid in the flush cycle → no cdb_o.valid on the next two cycles; all src_ready=1 afterwards.
5. Branch pass-through: CMP sends br_en=1, br_target=0x6000_0040, tag=7 → cdb_o carries the identical br_en, br_target and tag.
6. Async reset: assert rst_n mid-burst, between clock edges → cdb_o is zero and src_ready=0 immediately; after release, the first broadcast comes from a fresh enqueue and rr_ptr starts at 0.
